// File: rtl/demux1to64_pipelined_if.sv
// Handshake and lane bus for the 1-to-64 pipelined demultiplexer.
// The master drives words in; the slave returns per-lane data and strobes.
interface demux1to64_pipelined_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]        din;
    logic [5:0]               sel;
    logic                     in_valid;
    logic                     stall;
    logic                     in_ready;
    logic [63:0][DATA_W-1:0]  dout;
    logic [63:0]              out_valid;
    logic                     busy;

    modport master (
        output din, sel, in_valid, stall,
        input  in_ready, dout, out_valid, busy
    );

    modport slave (
        input  din, sel, in_valid, stall,
        output in_ready, dout, out_valid, busy
    );
endinterface

// File: rtl/demux1to64_pipelined.sv
// Three-stage 1-to-64 demux: capture, group decode, lane decode/write.
// Define DEMUX1TO64_CLEAR_EN to zero every unaddressed lane on each advance.
module demux1to64_pipelined #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux1to64_pipelined_if.slave bus
);
    logic                     r_s1_v;
    logic [DATA_W-1:0]        r_s1_d;
    logic [5:0]               r_s1_sel;
    logic                     r_s2_v;
    logic [DATA_W-1:0]        r_s2_d;
    logic [3:0]               r_s2_grp;
    logic [3:0]               r_s2_lo;
    logic                     r_s3_v;
    logic [63:0]              r_ov;
    logic [63:0][DATA_W-1:0]  r_dout;
    logic [63:0]              w_hit;

    // Lane hit = one-hot group from S2 crossed with the low nibble.
    always_comb begin
        w_hit = '0;
        for (int g = 0; g < 4; g++) begin
            for (int l = 0; l < 16; l++) begin
                w_hit[g*16+l] = r_s2_grp[g] && (r_s2_lo == 4'(l));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_d   <= '0;
            r_s1_sel <= '0;
            r_s2_v   <= 1'b0;
            r_s2_d   <= '0;
            r_s2_grp <= '0;
            r_s2_lo  <= '0;
            r_s3_v   <= 1'b0;
            r_ov     <= '0;
            r_dout   <= '0;
        end else if (!bus.stall) begin
            r_s1_v   <= bus.in_valid;
            r_s1_d   <= bus.din;
            r_s1_sel <= bus.sel;
            r_s2_v   <= r_s1_v;
            r_s2_d   <= r_s1_d;
            r_s2_grp <= r_s1_v ? (4'b0001 << r_s1_sel[5:4]) : 4'b0000;
            r_s2_lo  <= r_s1_sel[3:0];
            r_s3_v   <= r_s2_v;
            r_ov     <= w_hit;
            for (int i = 0; i < 64; i++) begin
                if (w_hit[i]) begin
                    r_dout[i] <= r_s2_d;
                end else begin
`ifdef DEMUX1TO64_CLEAR_EN
                    r_dout[i] <= '0;
`else
                    r_dout[i] <= r_dout[i];
`endif
                end
            end
        end
    end

    assign bus.in_ready  = ~bus.stall;
    assign bus.dout      = r_dout;
    assign bus.out_valid = r_ov;
    assign bus.busy      = r_s1_v | r_s2_v | r_s3_v;
endmodule

// File: tb/tb_demux1to64_pipelined.sv
// Randomised and directed bench for demux1to64_pipelined.
// Reference model: queue of accepted slots, delivery two advances later.
module tb_demux1to64_pipelined;
    typedef struct packed {
        bit         v;
        logic [5:0] s;
        logic [7:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    demux1to64_pipelined_if #(.DATA_W(8)) bus();

    demux1to64_pipelined #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    ent_t hist[$];
    logic [63:0]       exp_ov;
    logic [63:0][7:0]  exp_dout;
    bit                exp_busy;

    task automatic model_reset();
        ent_t z;
        z = '0;
        hist.delete();
        repeat (3) hist.push_back(z);
        exp_ov   = '0;
        exp_dout = '0;
        exp_busy = 1'b0;
    endtask

    task automatic step(input bit rn, input bit v, input bit st,
                        input logic [5:0] s, input logic [7:0] d);
        ent_t e;
        ent_t dl;
        rst_n        = rn;
        bus.in_valid = v;
        bus.stall    = st;
        bus.sel      = s;
        bus.din      = d;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else if (!st) begin
            e.v = v;
            e.s = s;
            e.d = d;
            hist.push_back(e);
            dl = hist[1];
            void'(hist.pop_front());
            exp_ov = dl.v ? (64'h1 << dl.s) : 64'h0;
`ifdef DEMUX1TO64_CLEAR_EN
            exp_dout = '0;
`endif
            if (dl.v) exp_dout[dl.s] = dl.d;
            exp_busy = hist[0].v | hist[1].v | hist[2].v;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 6'd9, 8'h77);
        n_chk++;
        if (bus.out_valid !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_ov got %h exp 0", bus.out_valid);
        end
        n_chk++;
        if (bus.dout !== '0) begin
            n_fail++;
            $display("FAIL reset_dout got %h exp 0", bus.dout);
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b exp 0", bus.busy);
        end
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 0", bus.in_ready);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    endtask

    task automatic test_single();
        step(1'b1, 1'b1, 1'b0, 6'd37, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 6'($urandom), 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 6'($urandom), 8'($urandom));
        n_chk++;
        if (bus.out_valid !== (64'h1 << 37) || bus.dout[37] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_hit got ov=%h d=%h exp ov=%h d=a5",
                     bus.out_valid, bus.dout[37], 64'h1 << 37);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        n_chk++;
        if (bus.out_valid !== 64'h0) begin
            n_fail++;
            $display("FAIL single_once got %h exp 0", bus.out_valid);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 67; i++) begin
            step(1'b1, i < 64, 1'b0, 6'(i), 8'(i));
            n_chk++;
            if (bus.out_valid !== exp_ov || bus.dout !== exp_dout) begin
                n_fail++;
                $display("FAIL sweep_%0d got ov=%h exp ov=%h", i,
                         bus.out_valid, exp_ov);
            end
            n_chk++;
            if (i >= 2 && bus.out_valid !== (64'h1 << (i - 2))) begin
                n_fail++;
                $display("FAIL sweep_strobe_%0d got %h", i, bus.out_valid);
            end
        end
        for (int i = 0; i < 64; i++) begin
            n_chk++;
`ifdef DEMUX1TO64_CLEAR_EN
            if (bus.dout[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL sweep_clear_%0d got %h exp 00", i, bus.dout[i]);
            end
`else
            if (bus.dout[i] !== 8'(i)) begin
                n_fail++;
                $display("FAIL sweep_hold_%0d got %h exp %h", i,
                         bus.dout[i], 8'(i));
            end
`endif
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b1, 1'b0, 6'd5, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 6'($urandom), 8'($urandom));
            n_chk++;
            if (bus.out_valid !== 64'h0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got ov=%h rdy=%b exp 0/0", i,
                         bus.out_valid, bus.in_ready);
            end
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        n_chk++;
        if (bus.out_valid !== 64'h0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_early got ov=%h rdy=%b", bus.out_valid,
                     bus.in_ready);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        n_chk++;
        if (bus.out_valid !== (64'h1 << 5) || bus.dout[5] !== 8'h3C) begin
            n_fail++;
            $display("FAIL stall_deliver got ov=%h d=%h exp lane5 3c",
                     bus.out_valid, bus.dout[5]);
        end
    endtask

    task automatic test_same_lane();
        step(1'b1, 1'b1, 1'b0, 6'd63, 8'h11);
        step(1'b1, 1'b1, 1'b0, 6'd63, 8'h22);
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        n_chk++;
        if (bus.out_valid !== (64'h1 << 63) || bus.dout[63] !== 8'h11) begin
            n_fail++;
            $display("FAIL same_first got ov=%h d=%h exp d=11",
                     bus.out_valid, bus.dout[63]);
        end
        step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        n_chk++;
        if (bus.out_valid !== (64'h1 << 63) || bus.dout[63] !== 8'h22) begin
            n_fail++;
            $display("FAIL same_second got ov=%h d=%h exp d=22",
                     bus.out_valid, bus.dout[63]);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0, 6'd12, 8'h5A);
        step(1'b1, 1'b1, 1'b0, 6'd50, 8'hC3);
        step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        n_chk++;
        if (bus.out_valid !== 64'h0 || bus.dout !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got ov=%h busy=%b exp 0/0",
                     bus.out_valid, bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
            n_chk++;
            if (bus.out_valid !== 64'h0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_after_%0d got ov=%h busy=%b", i,
                         bus.out_valid, bus.busy);
            end
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 19; i++) begin
            step(1'b1, (i % 2 == 0) && i < 16, 1'b0, 6'(i / 2), 8'($urandom));
            n_chk++;
            if (bus.out_valid !== exp_ov || bus.dout !== exp_dout ||
                bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL bubble_%0d got ov=%h busy=%b exp ov=%h busy=%b",
                         i, bus.out_valid, bus.busy, exp_ov, exp_busy);
            end
        end
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_idle got busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_random();
        bit rn;
        bit st;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 3) == 0);
            step(rn, 1'($urandom), st, 6'($urandom), 8'($urandom));
            n_chk++;
            if (bus.out_valid !== exp_ov || bus.dout !== exp_dout ||
                bus.busy !== exp_busy || bus.in_ready !== ~st) begin
                n_fail++;
                $display("FAIL rand_%0d got ov=%h busy=%b exp ov=%h busy=%b",
                         i, bus.out_valid, bus.busy, exp_ov, exp_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_sweep();
        test_stall();
        test_same_lane();
        test_reset_mid();
        test_bubbles();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux1to64_pipelined.md
DEMUX1TO64_PIPELINED -- requirements
Module: demux1to64_pipelined

Interface
REQ-001 SHALL have parameter: DATA_W, 8, bit width of each data word.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: din  input  DATA_W  data word to route.
REQ-005 SHALL have port: sel  input  6  destination lane index 0..63.
REQ-006 SHALL have port: in_valid  input  1  din/sel valid this cycle.
REQ-007 SHALL have port: stall  input  1  freeze the pipeline.
REQ-008 SHALL have port: in_ready  output  1  input accepted this cycle when high with in_valid.
REQ-009 SHALL have port: dout  output  [63:0][DATA_W-1:0]  per-lane registered data.
REQ-010 SHALL have port: out_valid  output  64  per-lane one-cycle valid strobe, one-hot or zero.
REQ-011 SHALL have port: busy  output  1  high while any pipeline stage holds a valid word.

Function
REQ-012 in_ready SHALL equal ~stall, combinationally; a transfer occurs on a rising edge where in_valid && in_ready.
REQ-013 The pipeline SHALL have three register stages: S1 captures din/sel/valid; S2 decodes sel[5:4] to one of 4 groups; S3 decodes sel[3:0] and writes the lane register.
REQ-014 Latency SHALL be exactly 3 clocks: a transfer at edge N raises out_valid[sel] and updates dout[sel] after edge N+2, with no stall.
REQ-015 Throughput SHALL be one word per clock; back-to-back transfers to any lanes, including the same lane, SHALL each produce their own strobe in order.
REQ-016 out_valid SHALL be high for exactly one cycle per delivered word and SHALL never have more than one bit set.
REQ-017 When stall=1, all stage registers, dout and out_valid SHALL hold their values; no new word enters; delivery resumes on the first un-stalled edge with latency counted in un-stalled edges.
REQ-018 Without the clear option, dout lanes not addressed by S3 SHALL hold their last delivered value indefinitely.
REQ-019 sel SHALL be captured with din at transfer; later sel changes SHALL not affect in-flight words.
REQ-020 A cycle with in_valid=0 (bubble) SHALL propagate as an invalid stage and SHALL produce no strobe and no lane write.
REQ-021 busy SHALL be the OR of the S1, S2 and S3 valid bits.

Reset
REQ-022 When rst_n=0 at a rising edge, all stage valid bits, all dout lanes, out_valid and busy SHALL be 0 after that edge, overriding stall.
REQ-023 Reset mid-flight SHALL discard all in-flight words; no strobe from a pre-reset transfer SHALL appear after reset.
REQ-024 in_ready SHALL follow ~stall during reset; transfers presented while rst_n=0 SHALL be discarded.

Configuration
REQ-025 Macro DEMUX1TO64_CLEAR_EN SHALL select lane hold behaviour.
REQ-026 With DEMUX1TO64_CLEAR_EN defined, on every un-stalled edge each lane not written by S3 SHALL load 0, so dout is non-zero only on the strobed lane.
REQ-027 Without DEMUX1TO64_CLEAR_EN, the behaviour in REQ-018 SHALL apply; the two builds SHALL have identical out_valid timing.

Verification
REQ-028 Single word: din=8'hA5, sel=6'd37, in_valid for 1 cycle at edge 0 -> out_valid=64'h1<<37 and dout[37]=8'hA5 after edge 2, only for that cycle.
REQ-029 Sweep: 64 back-to-back words din=i, sel=i -> 64 consecutive one-hot strobes, lane i = i, no gaps; the hold build keeps all 64 values afterwards, and the clear build returns all lanes to 0.
REQ-030 Stall: transfer sel=5 din=8'h3C, then stall=1 for 4 cycles after edge 0 -> no strobe during stall, in_ready=0; strobe on lane 5 after the 3rd un-stalled edge.
REQ-031 Same-lane repeat: din 8'h11 then 8'h22 to sel=63 on consecutive edges -> two consecutive strobes on lane 63 with values 8'h11 then 8'h22.
REQ-032 Reset mid-flight: two words in flight, rst_n=0 for one edge -> all outputs 0 and busy=0 after that edge; no strobes afterwards.
REQ-033 Bubbles: alternating in_valid 1/0 with sel=0..7 -> strobes on alternate cycles, with busy staying high until 3 edges after the last transfer.
